// File: rtl/stoch_sat_sub_arb.sv
// Round-robin arbiter/sequencer sharing one stochastic saturating-subtract matrix
// among NUM_REQ requesters. Each job flushes the subtractor's saturation state for
// one cycle, then streams exactly STREAM_LEN bit cycles from the owner's A/B inputs.
// Optional feature: define STOCH_SAT_SUB_ARB_ABORT_EN to abort a job as soon as the
// owner drops its request during RUN.
module stoch_sat_sub_arb #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned NUM_ROWS   = 2,
  parameter int unsigned NUM_COLS   = 2,
  parameter int unsigned STREAM_LEN = 256
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*NUM_ROWS*NUM_COLS-1:0] req_a,
  input  logic [NUM_REQ*NUM_ROWS*NUM_COLS-1:0] req_b,
  output logic [NUM_REQ-1:0]              grant,
  output logic [NUM_ROWS*NUM_COLS-1:0]    y_out,
  output logic                            y_valid,
  output logic [NUM_REQ-1:0]              done,
  output logic                            busy,
  output logic                            sub_nrst,
  output logic [NUM_ROWS*NUM_COLS-1:0]    sub_a,
  output logic [NUM_ROWS*NUM_COLS-1:0]    sub_b,
  input  logic [NUM_ROWS*NUM_COLS-1:0]    sub_y
);

  localparam int unsigned E  = NUM_ROWS * NUM_COLS;
  localparam int unsigned PW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(STREAM_LEN + 1);
  localparam logic [CW-1:0] LastCnt = CW'(STREAM_LEN - 1);

  typedef enum logic [1:0] {StIdle, StFlush, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic                 pick_found;
  logic [PW-1:0]        pick_idx;
  logic [PW-1:0]        scan;
  logic [NUM_REQ-1:0]   pick_onehot;
  logic [PW-1:0]        next_ptr;
  logic [E-1:0]         mux_a, mux_b;
  logic                 run;

  // Pick the first asserted request scanning upward from rr_ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan = PW'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!pick_found && req[scan]) begin
        pick_found = 1'b1;
        pick_idx   = scan;
      end
    end
  end

  assign pick_onehot = NUM_REQ'(1) << pick_idx;
  // The finishing owner becomes lowest priority for the next arbitration.
  assign next_ptr    = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + PW'(1);

  // Next-state logic for the job sequencer.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (pick_found) begin
          grant_d = pick_onehot;
          owner_d = pick_idx;
          state_d = StFlush;
        end
      end
      StFlush: begin
        cnt_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StDone;
        end
`ifdef STOCH_SAT_SUB_ARB_ABORT_EN
        // Owner withdrew: drop the job without a done pulse.
        if (!req[owner_q]) begin
          state_d  = StIdle;
          grant_d  = '0;
          cnt_d    = '0;
          rr_ptr_d = next_ptr;
        end
`endif
      end
      StDone: begin
        state_d  = StIdle;
        grant_d  = '0;
        cnt_d    = '0;
        rr_ptr_d = next_ptr;
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // One-hot grant selects the owner's A/B slices.
  always_comb begin
    mux_a = '0;
    mux_b = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (grant_q[r]) begin
        mux_a = mux_a | req_a[r*E +: E];
        mux_b = mux_b | req_b[r*E +: E];
      end
    end
  end

  assign run      = (state_q == StRun);
  assign grant    = grant_q;
  assign busy     = (state_q != StIdle);
  assign y_valid  = run;
  assign y_out    = run ? sub_y : '0;
  // Subtractor is held in reset everywhere but RUN, which also clears it during FLUSH.
  assign sub_nrst = run;
  assign sub_a    = run ? mux_a : '0;
  assign sub_b    = run ? mux_b : '0;
  assign done     = (state_q == StDone) ? grant_q : '0;

endmodule

// File: tb/tb_stoch_sat_sub_arb.sv
// Self-checking bench for stoch_sat_sub_arb (NUM_REQ=4, 2x2, STREAM_LEN=8).
// A small saturating-subtractor model stands in for the shared datapath.
module tb_stoch_sat_sub_arb;

  localparam int N  = 4;
  localparam int E  = 4;
  localparam int L  = 8;
  localparam int AW = N * E;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [N-1:0]  req = '0;
  logic [AW-1:0] req_a = '0;
  logic [AW-1:0] req_b = '0;
  logic [N-1:0]  grant;
  logic [E-1:0]  y_out;
  logic          y_valid;
  logic [N-1:0]  done;
  logic          busy;
  logic          sub_nrst;
  logic [E-1:0]  sub_a;
  logic [E-1:0]  sub_b;
  logic [E-1:0]  sub_y;

  stoch_sat_sub_arb #(
    .NUM_REQ    (N),
    .NUM_ROWS   (2),
    .NUM_COLS   (2),
    .STREAM_LEN (L)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .req      (req),
    .req_a    (req_a),
    .req_b    (req_b),
    .grant    (grant),
    .y_out    (y_out),
    .y_valid  (y_valid),
    .done     (done),
    .busy     (busy),
    .sub_nrst (sub_nrst),
    .sub_a    (sub_a),
    .sub_b    (sub_b),
    .sub_y    (sub_y)
  );

  always #5 CLK = ~CLK;

  // Shared subtractor stand-in: surplus B bits build a saturating debt that
  // swallows later A-only bits; cleared while nRST is low.
  int sat [E];
  always @(posedge CLK) begin
    for (int k = 0; k < E; k++) begin
      if (!sub_nrst) sat[k] <= 0;
      else if (sub_a[k] && !sub_b[k] && sat[k] > 0) sat[k] <= sat[k] - 1;
      else if (!sub_a[k] && sub_b[k] && sat[k] < 3) sat[k] <= sat[k] + 1;
    end
  end
  always_comb begin
    sub_y = '0;
    for (int k = 0; k < E; k++)
      sub_y[k] = sub_nrst && sub_a[k] && !sub_b[k] && (sat[k] == 0);
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    if (obs !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, want, $time);
    end
  endtask

  // Reference model: current owner (-1 idle), cycles since grant, next-priority index.
  int m_owner = -1;
  int m_age   = 0;
  int m_ptr   = 0;

  // Observed statistics for directed scenarios.
  int           yv_cnt, done_cnt;
  logic [N-1:0] done_last, prev_grant;
  logic [E-1:0] y_and, y_or;
  logic [N-1:0] gseq [$];

  task automatic clear_stats();
    yv_cnt = 0; done_cnt = 0; done_last = '0;
    y_and = '1; y_or = '0;
    gseq.delete();
  endtask

  task automatic model_edge();
    if (RST) begin
      m_owner = -1; m_age = 0; m_ptr = 0;
    end else if (m_owner < 0) begin
      for (int i = 0; i < N; i++) begin
        if (m_owner < 0 && req[(m_ptr + i) % N]) begin
          m_owner = (m_ptr + i) % N;
          m_age   = 0;
        end
      end
    end else begin
`ifdef STOCH_SAT_SUB_ARB_ABORT_EN
      if (m_age >= 1 && m_age <= L && !req[m_owner]) begin
        m_ptr = (m_owner + 1) % N; m_owner = -1;
      end else
`endif
      if (m_age == L + 1) begin
        m_ptr = (m_owner + 1) % N; m_owner = -1;
      end else begin
        m_age++;
      end
    end
  endtask

  // One clock: compare all outputs mid-cycle, then advance the model at the edge.
  task automatic step();
    logic [N-1:0] eg, ed;
    logic [E-1:0] ea, eb, ey;
    logic         run;
    @(negedge CLK);
    eg = '0; ed = '0; ea = '0; eb = '0; ey = '0;
    run = (m_owner >= 0) && (m_age >= 1) && (m_age <= L);
    if (m_owner >= 0) begin
      eg = N'(1) << m_owner;
      if (m_age == L + 1) ed = eg;
      if (run) begin
        ea = req_a[m_owner*E +: E];
        eb = req_b[m_owner*E +: E];
        ey = sub_y;
      end
    end
    check("grant",    32'(grant),    32'(eg));
    check("busy",     32'(busy),     32'(m_owner >= 0));
    check("y_valid",  32'(y_valid),  32'(run));
    check("done",     32'(done),     32'(ed));
    check("sub_nrst", 32'(sub_nrst), 32'(run));
    check("sub_a",    32'(sub_a),    32'(ea));
    check("sub_b",    32'(sub_b),    32'(eb));
    check("y_out",    32'(y_out),    32'(ey));
    if (y_valid) begin
      yv_cnt++; y_and = y_and & y_out; y_or = y_or | y_out;
    end
    if (done != '0) begin
      done_cnt++; done_last = done;
    end
    if (grant != '0 && prev_grant == '0) gseq.push_back(grant);
    prev_grant = grant;
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    steps(2);
    RST = 1'b0;
  endtask

  logic [N-1:0] exp_rr [5];

  initial begin
    prev_grant = '0;
    clear_stats();

    // Reset with all requests asserted.
    req = 4'b1111;
    do_reset();
    check("rst_grant",    32'(grant),    32'(0));
    check("rst_sub_nrst", 32'(sub_nrst), 32'(0));
    check("rst_busy",     32'(busy),     32'(0));
    check("rst_done",     32'(done),     32'(0));

    // Single job for requester 2, A=1 B=0.
    req = 4'b0000;
    do_reset();
    clear_stats();
    req = 4'b0100; req_a = '1; req_b = '0;
    step();
    check("single_grant", 32'(grant), 32'(4'b0100));
    steps(L + 2);
    req = 4'b0000;
    steps(2);
    check("single_yv_cnt",   32'(yv_cnt),    32'(L));
    check("single_done_cnt", 32'(done_cnt),  32'(1));
    check("single_done_bit", 32'(done_last), 32'(4'b0100));
    check("single_y",        32'(y_and),     32'(4'hF));

    // Round-robin with all requesters held.
    do_reset();
    clear_stats();
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      req_a = AW'($urandom); req_b = AW'($urandom);
      steps(L + 3);
    end
    exp_rr[0] = 4'b0001; exp_rr[1] = 4'b0010; exp_rr[2] = 4'b0100;
    exp_rr[3] = 4'b1000; exp_rr[4] = 4'b0001;
    check("rr_jobs", 32'(gseq.size()), 32'(5));
    for (int i = 0; i < 5; i++)
      check($sformatf("rr_order%0d", i), 32'(i < gseq.size() ? gseq[i] : '0), 32'(exp_rr[i]));
    check("rr_yv_cnt",   32'(yv_cnt),   32'(5 * L));
    check("rr_done_cnt", 32'(done_cnt), 32'(5));

    // Saturation clear between jobs of the same requester.
    req = 4'b0000;
    do_reset();
    req = 4'b0010;
    for (int j = 0; j < 3; j++) begin
      clear_stats();
      req_a = AW'($urandom); req_b = AW'($urandom);
      req_a[1*E +: E] = (j == 1) ? 4'h0 : 4'hF;
      req_b[1*E +: E] = (j == 1) ? 4'hF : 4'h0;
      steps(L + 3);
      check($sformatf("sat_job%0d_yv", j), 32'(yv_cnt), 32'(L));
      if (j == 1) check("sat_job1_y", 32'(y_or),  32'(4'h0));
      else        check($sformatf("sat_job%0d_y", j), 32'(y_and), 32'(4'hF));
    end

    // Mid-job reset: move the pointer, then reset part way through a job.
    req = 4'b0000;
    do_reset();
    req = 4'b0100;
    steps(L + 3);
    clear_stats();
    req = 4'b1111;
    steps(2 + 4);
    check("midrst_grant_before", 32'(grant), 32'(4'b1000));
    RST = 1'b1;
    step();
    check("midrst_grant", 32'(grant), 32'(0));
    check("midrst_busy",  32'(busy),  32'(0));
    RST = 1'b0;
    step();
    check("midrst_next_grant", 32'(grant), 32'(4'b0001));
    check("midrst_no_done",    32'(done_cnt), 32'(0));

`ifdef STOCH_SAT_SUB_ARB_ABORT_EN
    // Owner drops its request at cnt=3.
    req = 4'b0000;
    do_reset();
    clear_stats();
    req = 4'b0110;
    steps(2 + 3);
    req = 4'b0100;
    step();
    check("abort_grant", 32'(grant), 32'(0));
    check("abort_busy",  32'(busy),  32'(0));
    step();
    check("abort_next_grant", 32'(grant), 32'(4'b0100));
    check("abort_no_done",    32'(done_cnt), 32'(0));
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) req = N'($urandom);
      req_a = AW'($urandom);
      req_b = AW'($urandom);
      RST   = ($urandom_range(0, 249) == 0);
      step();
    end
    RST = 1'b0;
    steps(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
